// File: rtl/random_shot_scheduler.sv
// random_shot_scheduler: requests random bytes from the latched-counter generator and
// uses them to schedule enemy shots (random frame delay, then random column, then a
// fire request held until the shot logic acknowledges it).
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   enable       scheduling runs while high (ignored once a shot is pending in FIRE)
//   startOfFrame one-cycle pulse per video frame, paces the delay countdown
//   rand_val     generator dout, sampled on the 2nd capture cycle after each request
//   fire_ack     shot logic accepted the pending shot
//   rand_req     one-cycle pulse to the generator's rise input
//   fire         shot request, held until fire_ack
//   fire_col     column of the pending / last shot, 0..COLUMNS-1
//   busy         high in every state except IDLE
//   shot_count   accepted shots, wraps 255->0
module random_shot_scheduler #(
  parameter int SIZE_BITS  = 8,
  parameter int MIN_DELAY  = 16,
  parameter int DELAY_BITS = 6,
  parameter int COLUMNS    = 11,
  parameter int COL_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 startOfFrame,
  input  logic [SIZE_BITS-1:0] rand_val,
  input  logic                 fire_ack,
  output logic                 rand_req,
  output logic                 fire,
  output logic [COL_BITS-1:0]  fire_col,
  output logic                 busy,
  output logic [7:0]           shot_count
);

  typedef enum logic [2:0] {IDLE, REQ_D, CAP_D, WAIT, REQ_C, CAP_C, FIRE} state_t;

  localparam logic [COL_BITS:0]   COLS_EXT = (COL_BITS+1)'(COLUMNS);
  localparam logic [COL_BITS-1:0] COLS_LO  = COL_BITS'(COLUMNS);

  state_t              state;
  logic                cap_second;   // set during the 2nd capture cycle
  logic [7:0]          delay;
  logic [COL_BITS-1:0] col_raw;
  logic [COL_BITS-1:0] col_pick;
  logic [7:0]          delay_load;
  logic                unused_rand;

  // The column range covers more than half of the COL_BITS space, so a single
  // subtraction folds any out-of-range value back into 0..COLUMNS-1.
  assign col_raw    = rand_val[COL_BITS-1:0];
  assign col_pick   = ({1'b0, col_raw} >= COLS_EXT) ? col_raw - COLS_LO : col_raw;
  // Parameter limits keep this sum inside 8 bits.
  assign delay_load = 8'(MIN_DELAY) + 8'(rand_val[DELAY_BITS-1:0]);
  // Upper random bits are intentionally ignored.
  assign unused_rand = ^rand_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rand_req   <= 1'b0;
      fire       <= 1'b0;
      fire_col   <= '0;
      busy       <= 1'b0;
      shot_count <= 8'd0;
      delay      <= 8'd0;
      cap_second <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= REQ_D;
            rand_req <= 1'b1;
            busy     <= 1'b1;
          end
        end

        REQ_D, REQ_C: begin
          rand_req   <= 1'b0;
          cap_second <= 1'b0;
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            delay <= 8'd0;
          end else if (state == REQ_D) begin
            state <= CAP_D;
          end else begin
            state <= CAP_C;
          end
        end

        // Two capture cycles: rand_val is valid by the 2nd one, and rand_req
        // stays low long enough for the generator's edge detector to re-arm.
        CAP_D: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            delay <= 8'd0;
          end else if (!cap_second) begin
            cap_second <= 1'b1;
          end else begin
            delay <= delay_load;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            delay <= 8'd0;
          end else if (startOfFrame) begin
            delay <= delay - 8'd1;
            if (delay == 8'd1) begin
              state    <= REQ_C;
              rand_req <= 1'b1;
            end
          end
        end

        CAP_C: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
            delay <= 8'd0;
          end else if (!cap_second) begin
            cap_second <= 1'b1;
          end else begin
            fire_col <= col_pick;
            fire     <= 1'b1;
            state    <= FIRE;
          end
        end

        // A pending shot always completes via ack; enable only chooses
        // between going idle and starting the next shot immediately.
        FIRE: begin
          if (fire_ack) begin
            fire       <= 1'b0;
            shot_count <= shot_count + 8'd1;
            if (enable) begin
              state    <= REQ_D;
              rand_req <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rand_req <= 1'b0;
          fire     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_shot_scheduler.sv
module tb_random_shot_scheduler;

  localparam int MIN_DELAY = 16;
  localparam int COLUMNS   = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       fire_ack = 1'b0;
  logic [7:0] rand_val = 8'd0;
  logic       rand_req;
  logic       fire;
  logic       busy;
  logic [3:0] fire_col;
  logic [7:0] shot_count;

  int tests_run = 0;
  int failed = 0;
  int frame_gap = 0;
  int exp_cnt = 0;

  // rand_req pulse-shape monitor
  int   min_gap = 1000;
  int   low_run = 1000;
  int   width_bad = 0;
  int   pulses = 0;
  logic prev_req = 1'b0;

  random_shot_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .startOfFrame (startOfFrame),
    .rand_val     (rand_val),
    .fire_ack     (fire_ack),
    .rand_req     (rand_req),
    .fire         (fire),
    .fire_col     (fire_col),
    .busy         (busy),
    .shot_count   (shot_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    prev_req <= rand_req;
    if (rand_req === 1'b1) begin
      pulses  <= pulses + 1;
      low_run <= 0;
      if (prev_req === 1'b1) width_bad <= width_bad + 1;
      else if (low_run < min_gap) min_gap <= low_run;
    end else begin
      low_run <= low_run + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_delay(input logic [7:0] v);
    return MIN_DELAY + (int'(v) % 64);
  endfunction

  function automatic int exp_col(input logic [7:0] v);
    int c = int'(v) % 16;
    return (c >= COLUMNS) ? c - COLUMNS : c;
  endfunction

  // Entry: the cycle in which the delay request pulse is visible.
  // Presents dv only in the single cycle where it must be captured (and cv
  // likewise), counts frames until the column request, reports what fired.
  task automatic shot(input logic [7:0] dv, input logic [7:0] cv,
                      output int nfr, output bit req_ok, output bit fire_ok,
                      output logic [3:0] col, output bit to);
    bit early;
    req_ok = (rand_req === 1'b1);
    fire_ok = 1'b1;
    col = 4'hx;
    early = 1'b0;
    rand_val = ~dv;
    tick();
    if (rand_req !== 1'b0) req_ok = 1'b0;
    tick();
    if (rand_req !== 1'b0) req_ok = 1'b0;
    rand_val = dv;
    tick();
    rand_val = ~dv;
    nfr = 0;
    to = 1'b0;
    for (int f = 0; f < 300; f++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      nfr++;
      if (rand_req === 1'b1) break;
      for (int g = 0; g < frame_gap; g++) begin
        tick();
        if (rand_req === 1'b1) early = 1'b1;
      end
      if (early) break;
    end
    if (rand_req !== 1'b1 || early) begin
      to = 1'b1;
      return;
    end
    rand_val = ~cv;
    tick();
    if (fire !== 1'b0) fire_ok = 1'b0;
    tick();
    if (fire !== 1'b0) fire_ok = 1'b0;
    rand_val = cv;
    tick();
    rand_val = ~cv;
    if (fire !== 1'b1) fire_ok = 1'b0;
    col = fire_col;
  endtask

  task automatic test_reset();
    int req_seen;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    tests_run++; if (rand_req !== 1'b0) begin failed++; $display("FAIL reset_rand_req: got %0b want 0", rand_req); end
    tests_run++; if (fire !== 1'b0) begin failed++; $display("FAIL reset_fire: got %0b want 0", fire); end
    tests_run++; if (fire_col !== 4'd0) begin failed++; $display("FAIL reset_fire_col: got %0d want 0", fire_col); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (shot_count !== 8'd0) begin failed++; $display("FAIL reset_shot_count: got %0d want 0", shot_count); end
    reset = 1'b0;
    tick();
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      startOfFrame = 1'b1;
      fire_ack = 1'b1;
      tick();
      if (rand_req !== 1'b0 || busy !== 1'b0) req_seen++;
      startOfFrame = 1'b0;
      fire_ack = 1'b0;
      tick();
      if (rand_req !== 1'b0 || busy !== 1'b0) req_seen++;
    end
    tests_run++; if (req_seen !== 0) begin failed++; $display("FAIL disabled_activity: got %0d active cycles want 0", req_seen); end
    tests_run++; if (shot_count !== 8'd0) begin failed++; $display("FAIL disabled_count: got %0d want 0", shot_count); end
  endtask

  task automatic test_basic();
    int nfr; bit req_ok, fire_ok, to; logic [3:0] col;
    frame_gap = 1;
    enable = 1'b1;
    tick();
    shot(8'h05, 8'h0D, nfr, req_ok, fire_ok, col, to);
    tests_run++; if (to !== 1'b0) begin failed++; $display("FAIL basic_timeout: got %0b want 0", to); end
    tests_run++; if (req_ok !== 1'b1) begin failed++; $display("FAIL basic_req_pulse: got %0b want 1", req_ok); end
    tests_run++; if (nfr !== exp_delay(8'h05)) begin failed++; $display("FAIL basic_delay: got %0d want %0d", nfr, exp_delay(8'h05)); end
    tests_run++; if (fire_ok !== 1'b1) begin failed++; $display("FAIL basic_fire_timing: got %0b want 1", fire_ok); end
    tests_run++; if (col !== 4'(exp_col(8'h0D))) begin failed++; $display("FAIL basic_col: got %0d want %0d", col, exp_col(8'h0D)); end
    fire_ack = 1'b1;
    enable = 1'b0;
    tick();
    fire_ack = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    tests_run++; if (fire !== 1'b0) begin failed++; $display("FAIL basic_fire_drop: got %0b want 0", fire); end
    tests_run++; if (shot_count !== 8'(exp_cnt)) begin failed++; $display("FAIL basic_count: got %0d want %0d", shot_count, exp_cnt); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL basic_idle: got busy %0b want 0", busy); end
  endtask

  task automatic test_col_wrap();
    logic [7:0] cvs [3] = '{8'h0A, 8'h0B, 8'h0F};
    int nfr; bit req_ok, fire_ok, to; logic [3:0] col;
    frame_gap = 0;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      shot(8'h00, cvs[i], nfr, req_ok, fire_ok, col, to);
      tests_run++; if (to !== 1'b0 || nfr !== exp_delay(8'h00)) begin failed++; $display("FAIL wrap_delay[%0d]: got %0d want %0d", i, nfr, exp_delay(8'h00)); end
      tests_run++; if (col !== 4'(exp_col(cvs[i]))) begin failed++; $display("FAIL wrap_col[%0d]: got %0d want %0d", i, col, exp_col(cvs[i])); end
      fire_ack = 1'b1;
      enable = (i < 2);
      tick();
      fire_ack = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      tests_run++; if (shot_count !== 8'(exp_cnt) || fire !== 1'b0) begin failed++; $display("FAIL wrap_ack[%0d]: got count %0d fire %0b want %0d 0", i, shot_count, fire, exp_cnt); end
      tests_run++; if (rand_req !== 1'(i < 2)) begin failed++; $display("FAIL wrap_b2b_req[%0d]: got %0b want %0b", i, rand_req, i < 2); end
    end
  endtask

  task automatic test_fire_hold();
    int nfr, hold_bad, req_seen; bit req_ok, fire_ok, to; logic [3:0] col;
    frame_gap = 0;
    enable = 1'b1;
    tick();
    shot(8'h33, 8'h09, nfr, req_ok, fire_ok, col, to);
    tests_run++; if (to !== 1'b0 || fire_ok !== 1'b1) begin failed++; $display("FAIL hold_reach_fire: got to %0b fire_ok %0b want 0 1", to, fire_ok); end
    enable = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fire !== 1'b1 || fire_col !== col || busy !== 1'b1) hold_bad++;
    end
    tests_run++; if (hold_bad !== 0) begin failed++; $display("FAIL hold_fire_stable: got %0d bad cycles want 0", hold_bad); end
    tests_run++; if (shot_count !== 8'(exp_cnt)) begin failed++; $display("FAIL hold_no_count: got %0d want %0d", shot_count, exp_cnt); end
    fire_ack = 1'b1;
    tick();
    fire_ack = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    tests_run++; if (fire !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL hold_ack: got fire %0b busy %0b want 0 0", fire, busy); end
    tests_run++; if (shot_count !== 8'(exp_cnt)) begin failed++; $display("FAIL hold_count: got %0d want %0d", shot_count, exp_cnt); end
    tests_run++; if (fire_col !== col) begin failed++; $display("FAIL hold_col_kept: got %0d want %0d", fire_col, col); end
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      fire_ack = 1'b1;
      tick();
      if (rand_req !== 1'b0) req_seen++;
    end
    fire_ack = 1'b0;
    tests_run++; if (req_seen !== 0 || shot_count !== 8'(exp_cnt)) begin failed++; $display("FAIL hold_after_idle: got req %0d count %0d want 0 %0d", req_seen, shot_count, exp_cnt); end
  endtask

  task automatic test_enable_drop();
    int nfr, act; bit req_ok, fire_ok, to; logic [3:0] col;
    frame_gap = 1;
    enable = 1'b1;
    tick();
    rand_val = ~8'h05;
    tick();
    tick();
    rand_val = 8'h05;
    tick();
    rand_val = 8'h00;
    for (int i = 0; i < 5; i++) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
    end
    enable = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL drop_idle: got busy %0b want 0", busy); end
    act = 0;
    for (int i = 0; i < 30; i++) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
      if (rand_req !== 1'b0 || fire !== 1'b0 || busy !== 1'b0) act++;
      tick();
      if (rand_req !== 1'b0 || fire !== 1'b0 || busy !== 1'b0) act++;
    end
    tests_run++; if (act !== 0) begin failed++; $display("FAIL drop_quiet: got %0d active cycles want 0", act); end
    enable = 1'b1;
    tick();
    shot(8'h02, 8'h03, nfr, req_ok, fire_ok, col, to);
    tests_run++; if (req_ok !== 1'b1) begin failed++; $display("FAIL drop_new_req: got %0b want 1", req_ok); end
    tests_run++; if (to !== 1'b0 || nfr !== exp_delay(8'h02)) begin failed++; $display("FAIL drop_new_delay: got %0d want %0d", nfr, exp_delay(8'h02)); end
    tests_run++; if (col !== 4'(exp_col(8'h03))) begin failed++; $display("FAIL drop_col: got %0d want %0d", col, exp_col(8'h03)); end
    fire_ack = 1'b1;
    enable = 1'b0;
    tick();
    fire_ack = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    tests_run++; if (shot_count !== 8'(exp_cnt)) begin failed++; $display("FAIL drop_count: got %0d want %0d", shot_count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int nfr, act; bit req_ok, fire_ok, to; logic [3:0] col;
    frame_gap = 0;
    enable = 1'b1;
    tick();
    shot(8'h01, 8'h07, nfr, req_ok, fire_ok, col, to);
    tests_run++; if (fire !== 1'b1 || col !== 4'd7) begin failed++; $display("FAIL midfire_setup: got fire %0b col %0d want 1 7", fire, col); end
    reset = 1'b1;
    enable = 1'b0;
    tick();
    exp_cnt = 0;
    tests_run++; if (fire !== 1'b0 || rand_req !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL midfire_reset_ctl: got fire %0b req %0b busy %0b want 0 0 0", fire, rand_req, busy); end
    tests_run++; if (fire_col !== 4'd0 || shot_count !== 8'd0) begin failed++; $display("FAIL midfire_reset_data: got col %0d count %0d want 0 0", fire_col, shot_count); end
    reset = 1'b0;
    enable = 1'b1;
    tick();
    rand_val = 8'h10;
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
    end
    reset = 1'b1;
    enable = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b0 || rand_req !== 1'b0 || fire !== 1'b0 || shot_count !== 8'd0) begin failed++; $display("FAIL midwait_reset: got busy %0b req %0b fire %0b count %0d want all 0", busy, rand_req, fire, shot_count); end
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 5; i++) begin
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
      if (rand_req !== 1'b0 || busy !== 1'b0) act++;
    end
    tests_run++; if (act !== 0) begin failed++; $display("FAIL midwait_after: got %0d active cycles want 0", act); end
  endtask

  task automatic test_back_to_back();
    int nfr, hold_bad, n_shots; bit req_ok, fire_ok, to; logic [3:0] col;
    logic [7:0] dv, cv;
    bit saw_wrap;
    n_shots = 260;
    saw_wrap = 1'b0;
    enable = 1'b1;
    tick();
    for (int i = 0; i < n_shots; i++) begin
      dv = 8'($urandom);
      cv = 8'($urandom);
      frame_gap = $urandom_range(0, 1);
      shot(dv, cv, nfr, req_ok, fire_ok, col, to);
      tests_run++; if (to !== 1'b0 || nfr !== exp_delay(dv)) begin failed++; $display("FAIL b2b_delay[%0d]: got %0d want %0d (to %0b)", i, nfr, exp_delay(dv), to); end
      tests_run++; if (req_ok !== 1'b1 || fire_ok !== 1'b1) begin failed++; $display("FAIL b2b_timing[%0d]: got req_ok %0b fire_ok %0b want 1 1", i, req_ok, fire_ok); end
      tests_run++; if (col !== 4'(exp_col(cv))) begin failed++; $display("FAIL b2b_col[%0d]: got %0d want %0d", i, col, exp_col(cv)); end
      if (to) break;
      hold_bad = 0;
      repeat ($urandom_range(0, 3)) begin
        tick();
        if (fire !== 1'b1 || fire_col !== col) hold_bad++;
      end
      fire_ack = 1'b1;
      enable = (i != n_shots - 1);
      tick();
      fire_ack = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      if (exp_cnt == 0 && shot_count === 8'd0) saw_wrap = 1'b1;
      tests_run++; if (shot_count !== 8'(exp_cnt) || fire !== 1'b0 || hold_bad !== 0) begin failed++; $display("FAIL b2b_ack[%0d]: got count %0d fire %0b hold_bad %0d want %0d 0 0", i, shot_count, fire, hold_bad, exp_cnt); end
    end
    tests_run++; if (saw_wrap !== 1'b1) begin failed++; $display("FAIL count_wrap: got %0b want 1", saw_wrap); end
  endtask

  task automatic test_req_spacing();
    tick();
    tests_run++; if (min_gap < 2) begin failed++; $display("FAIL req_low_gap: got %0d want >=2", min_gap); end
    tests_run++; if (width_bad !== 0) begin failed++; $display("FAIL req_width: got %0d wide pulses want 0", width_bad); end
    tests_run++; if (pulses < 500) begin failed++; $display("FAIL req_pulses: got %0d want >=500", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_col_wrap();
    test_fire_hold();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    test_req_spacing();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/random_shot_scheduler.md
# random_shot_scheduler

Consumer-side partner for the latched-counter random generator. Drives the generator's edge-trigger input, captures the returned random byte, and uses it to schedule enemy shots: a random frame delay, then a random column, then a fire request that is held until the shot logic accepts it. Sits between the random generator and the enemy-shot/object logic, clocked by the pixel clock and paced by the start-of-frame strobe.

## Interface
- SIZE_BITS, 8, width of the random value input.
- MIN_DELAY, 16, minimum frames between shots; legal range 1 to 255-(2^DELAY_BITS-1).
- DELAY_BITS, 6, number of random LSBs added to MIN_DELAY (random part 0..63).
- COLUMNS, 11, number of enemy columns; legal range 2^(COL_BITS-1)+1 to 2^COL_BITS.
- COL_BITS, 4, width of fire_col.

- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  level; scheduling runs only while high.
- startOfFrame  input  1  one-cycle pulse per video frame.
- rand_val  input  SIZE_BITS  random value from the generator's dout.
- fire_ack  input  1  shot logic accepted the pending shot.
- rand_req  output  1  drives the generator's rise input; one-cycle pulses.
- fire  output  1  shot request, held high until acknowledged.
- fire_col  output  COL_BITS  column of the pending/last shot.
- busy  output  1  high in every state except IDLE.
- shot_count  output  8  accepted-shot counter, wraps 255->0.

## Operation
- Reset values: state IDLE, rand_req 0, fire 0, fire_col 0, busy 0, shot_count 0, delay counter 0.
- States: IDLE, REQ_D, CAP_D, WAIT, REQ_C, CAP_C, FIRE.
- IDLE: if enable, go to REQ_D next cycle.
- REQ_D: rand_req=1 for exactly this cycle, then REQ_D->CAP_D.
- CAP_D: rand_req=0; the counter stays in CAP_D for 2 cycles, so rand_req is low for at least 2 cycles between pulses and the generator's edge detector re-arms. On the 2nd CAP_D cycle, load delay = MIN_DELAY + rand_val[DELAY_BITS-1:0] (8-bit, no overflow by parameter rule) and go to WAIT.
- WAIT: each startOfFrame decrements delay. When a pulse decrements delay to 0, go to REQ_C on the next cycle. A startOfFrame that arrives in any other state is ignored.
- REQ_C / CAP_C: same request/capture sequence as REQ_D/CAP_D. On the 2nd CAP_C cycle, c = rand_val[COL_BITS-1:0]. fire_col <= (c >= COLUMNS) ? c-COLUMNS : c, always in 0..COLUMNS-1. Then go to FIRE.
- FIRE: fire=1, fire_col stable. When fire_ack is high in FIRE: fire drops next cycle, shot_count increments, and the FSM goes to IDLE, or directly to REQ_D if enable is still high.
- fire_ack outside FIRE: ignored, no count.
- enable low in REQ_D, CAP_D, WAIT, REQ_C, or CAP_C: go to IDLE next cycle and discard the pending delay or column. In FIRE, enable is ignored; a pending shot always completes via ack.
- reset has priority over everything in every state, including mid-WAIT and mid-FIRE. fire drops on the next edge.
- fire_col holds its last value outside FIRE.

## Timing
- rand_req pulse is 1 cycle wide. It is sampled 3 cycles after assertion (the generator registers the edge one cycle after rise and updates dout one cycle after that). Minimum low time between pulses: 2 cycles.
- Cycle timing from enable rising while IDLE:
  - cycle 1: REQ_D.
  - cycles 2-3: CAP_D; delay loaded at end of cycle 3.
  - WAIT lasts until the delay-th startOfFrame.
  - REQ_C, then CAP_C for 2 cycles.
  - fire high on the 4th cycle after WAIT exits.
- Latency from fire_ack to fire low: 1 cycle. In back-to-back mode, rand_req for the next shot is asserted in that same cycle.
- busy is registered from state and is valid in the same cycle as the state.

## Test plan
- Reset -> all outputs 0, state IDLE; startOfFrame or fire_ack pulses while enable=0 -> no rand_req, shot_count stays 0.
- enable=1, rand_val=0x05 at the delay capture, MIN_DELAY=16 -> delay 21. Then rand_val=0x0D at the column capture -> fire rises on the 4th cycle after the 21st startOfFrame with fire_col=2. fire_ack -> fire low 1 cycle later, shot_count=1.
- Column wrap: captured column values 0x0A, 0x0B, 0x0F -> fire_col 10, 0, 4.
- fire held 50 cycles with no ack and enable dropped mid-FIRE -> fire stays high, fire_col unchanged. Ack -> fire low, shot_count increments, state IDLE, no further rand_req.
- enable dropped after 5 of 21 frames in WAIT -> IDLE next cycle, no fire. Re-enable -> a fresh REQ_D pulse and a new delay is captured.
- reset asserted mid-WAIT and mid-FIRE -> next edge all outputs return to reset values, shot_count=0. With 256 acked shots -> shot_count wraps to 0; rand_req pulses always separated by ≥2 low cycles.
